// File: rtl/led_panel_if.sv
// led_panel_if: panel connector pins plus the row-limit input of the scan controller.
interface led_panel_if;
    logic [3:0] rowmax_in;
    logic       red_out;
    logic       green_out;
    logic       blue_out;
    logic       sclk_out;
    logic       latch_out;
    logic       blank_out;
    logic       aclk_out;
    logic       arst_out;

    modport master (
        input  rowmax_in,
        output red_out, green_out, blue_out, sclk_out, latch_out, blank_out, aclk_out, arst_out
    );

    modport slave (
        output rowmax_in,
        input  red_out, green_out, blue_out, sclk_out, latch_out, blank_out, aclk_out, arst_out
    );
endinterface

// File: rtl/led_panel_single_driver.sv
// led_panel_single_driver: refreshes a 16x8 RGB panel from a built-in test pattern,
// one row per 98 cycles (shift 32, latch 1, address 1, display 64).
module led_panel_single_driver (
    input logic         clk,
    input logic         reset,
    led_panel_if.master pnl
);
    typedef enum logic [1:0] {SHIFT, LATCH, ADVANCE, DISPLAY} state_t;

    state_t           state, state_n;
    logic [2:0]       row, row_n, rowmax_eff;
    logic [3:0]       pix, pix_n, col;
    logic [5:0]       cnt, cnt_n;
    logic [15:0][2:0] frame_buffer [8];
    logic             red_n, green_n, blue_n, sclk_n, latch_n, blank_n, aclk_n, arst_n;

    // Each pixel entry is {R,G,B}; the pattern is reloaded on every reset.
    function automatic logic [15:0][2:0] pattern(input logic [2:0] r);
        logic [15:0][2:0] p;
        logic [3:0]       cv;
        for (int c = 0; c < 16; c++) begin
            cv   = 4'(c);
            p[c] = {cv[0], r[0], cv[3:1] == r};
        end
        return p;
    endfunction

    assign rowmax_eff = pnl.rowmax_in[3] ? 3'd7 : pnl.rowmax_in[2:0];
    assign col        = ~pix;

    always_comb begin
        state_n = state;
        row_n   = row;
        pix_n   = pix;
        cnt_n   = cnt + 6'd1;
        red_n   = 1'b0;
        green_n = 1'b0;
        blue_n  = 1'b0;
        sclk_n  = 1'b0;
        latch_n = 1'b0;
        blank_n = 1'b1;
        aclk_n  = 1'b0;
        arst_n  = 1'b0;
        case (state)
            SHIFT: begin
                red_n   = frame_buffer[row][col][2];
                green_n = frame_buffer[row][col][1];
                blue_n  = frame_buffer[row][col][0];
                sclk_n  = cnt[0];
                pix_n   = cnt[0] ? pix + 4'd1 : pix;
                if (cnt == 6'd31) begin
                    state_n = LATCH;
                    cnt_n   = 6'd0;
                end
            end
            LATCH: begin
                latch_n = 1'b1;
                state_n = ADVANCE;
            end
            ADVANCE: begin
                arst_n  = row == 3'd0;
                aclk_n  = row != 3'd0;
                state_n = DISPLAY;
                cnt_n   = 6'd0;
            end
            default: begin
                blank_n = 1'b0;
                if (cnt == 6'd63) begin
                    state_n = SHIFT;
                    cnt_n   = 6'd0;
                    row_n   = row >= rowmax_eff ? 3'd0 : row + 3'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= SHIFT;
            row           <= 3'd0;
            pix           <= 4'd0;
            cnt           <= 6'd0;
            pnl.red_out   <= 1'b0;
            pnl.green_out <= 1'b0;
            pnl.blue_out  <= 1'b0;
            pnl.sclk_out  <= 1'b0;
            pnl.latch_out <= 1'b0;
            pnl.blank_out <= 1'b1;
            pnl.aclk_out  <= 1'b0;
            pnl.arst_out  <= 1'b0;
            for (int r = 0; r < 8; r++) frame_buffer[r] <= pattern(3'(r));
        end else begin
            state         <= state_n;
            row           <= row_n;
            pix           <= pix_n;
            cnt           <= cnt_n;
            pnl.red_out   <= red_n;
            pnl.green_out <= green_n;
            pnl.blue_out  <= blue_n;
            pnl.sclk_out  <= sclk_n;
            pnl.latch_out <= latch_n;
            pnl.blank_out <= blank_n;
            pnl.aclk_out  <= aclk_n;
            pnl.arst_out  <= arst_n;
        end
    end
endmodule

// File: tb/tb_led_panel_single_driver.sv
// tb_led_panel_single_driver: checks every output cycle against a row/offset model of the scan.
module tb_led_panel_single_driver;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   mrow = 0;
    int   moff = 0;
    int   n_aclk, n_arst, n_latch, n_sclk_rise;
    logic prev_sclk = 1'b0;

    led_panel_if ifc ();
    led_panel_single_driver dut (.clk(clk), .reset(reset), .pnl(ifc));

    always #5 clk = ~clk;

    // Vector order {red,green,blue,sclk,latch,blank,aclk,arst}.
    function automatic logic [7:0] model_out(input int r, input int off);
        logic [7:0] v;
        int c;
        v = 8'b0000_0100;
        if (off < 32) begin
            c    = 15 - off / 2;
            v[7] = (c % 2) == 1;
            v[6] = (r % 2) == 1;
            v[5] = (c / 2) == r;
            v[4] = (off % 2) == 1;
        end else if (off == 32) begin
            v[3] = 1'b1;
        end else if (off == 33) begin
            v[1] = r != 0;
            v[0] = r == 0;
        end else begin
            v[2] = 1'b0;
        end
        return v;
    endfunction

    function automatic logic [7:0] dut_out();
        return {ifc.red_out, ifc.green_out, ifc.blue_out, ifc.sclk_out,
                ifc.latch_out, ifc.blank_out, ifc.aclk_out, ifc.arst_out};
    endfunction

    task automatic clear_counts();
        n_aclk = 0; n_arst = 0; n_latch = 0; n_sclk_rise = 0;
    endtask

    task automatic run(input int n, input string name);
        logic [7:0] exp_v, got;
        int eff;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            exp_v = model_out(mrow, moff);
            if (moff == 97) begin
                eff  = ifc.rowmax_in > 7 ? 7 : int'(ifc.rowmax_in);
                mrow = mrow >= eff ? 0 : mrow + 1;
            end
            moff = (moff + 1) % 98;
            @(negedge clk);
            got = dut_out();
            total++;
            if (got !== exp_v) begin
                bad++;
                $display("FAIL %s row=%0d off=%0d got=%b want=%b", name, mrow, (moff + 97) % 98, got, exp_v);
            end
            n_aclk  += int'(got[1]);
            n_arst  += int'(got[0]);
            n_latch += int'(got[3]);
            if (got[4] && !prev_sclk) n_sclk_rise++;
            prev_sclk = got[4];
        end
    endtask

    task automatic do_reset(input int n, input string name);
        reset = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            mrow = 0; moff = 0;
            @(negedge clk);
            total++;
            if (dut_out() !== 8'b0000_0100) begin
                bad++;
                $display("FAIL %s reset_out got=%b want=00000100", name, dut_out());
            end
        end
        prev_sclk = 1'b0;
        reset = 1'b0;
    endtask

    task automatic check_count(input string name, input int got, input int want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic test_reset();
        ifc.rowmax_in = 4'd0;
        do_reset(3, "reset");
        clear_counts();
        run(32, "reset_shift");
        check_count("reset_sclk_rises", n_sclk_rise, 16);
        run(66, "reset_tail");
    endtask

    task automatic test_row0();
        ifc.rowmax_in = 4'd0;
        clear_counts();
        run(3 * 98, "row0");
        check_count("row0_arst", n_arst, 3);
        check_count("row0_aclk", n_aclk, 0);
        check_count("row0_latch", n_latch, 3);
    endtask

    task automatic test_full_frame();
        ifc.rowmax_in = 4'd7;
        clear_counts();
        run(2 * 784, "frame7");
        check_count("frame7_aclk", n_aclk, 14);
        check_count("frame7_arst", n_arst, 2);
        check_count("frame7_row", mrow, 0);
    endtask

    task automatic test_rowmax_clamp();
        ifc.rowmax_in = 4'd12;
        clear_counts();
        run(784, "clamp12");
        check_count("clamp12_aclk", n_aclk, 7);
        check_count("clamp12_arst", n_arst, 1);
    endtask

    task automatic test_rowmax_change();
        ifc.rowmax_in = 4'd7;
        run(5 * 98 + 50, "chg_pre");
        check_count("chg_row5", mrow, 5);
        ifc.rowmax_in = 4'd2;
        run(48, "chg_row5_tail");
        clear_counts();
        run(98, "chg_next");
        check_count("chg_next_arst", n_arst, 1);
        check_count("chg_next_aclk", n_aclk, 0);
        clear_counts();
        run(2 * 3 * 98, "chg_frames");
        check_count("chg_frames_aclk", n_aclk, 4);
        check_count("chg_frames_arst", n_arst, 2);
    endtask

    task automatic test_reset_mid();
        ifc.rowmax_in = 4'd7;
        run(98 + 17, "mid_pre");
        clear_counts();
        do_reset(1, "mid_reset");
        do_reset(1, "mid_reset_hold");
        run(98, "mid_after");
        check_count("mid_latch", n_latch, 1);
        check_count("mid_arst", n_arst, 1);
        check_count("mid_aclk", n_aclk, 0);
    endtask

    task automatic test_random();
        for (int p = 0; p < 24; p++) begin
            run(int'($urandom_range(97, 1)), "rand");
            ifc.rowmax_in = 4'($urandom_range(15, 0));
            run(49, "rand");
        end
    endtask

    initial begin
        ifc.rowmax_in = 4'd0;
        test_reset();
        test_row0();
        test_full_frame();
        test_rowmax_clamp();
        test_rowmax_change();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
